// File: rtl/ocra1_grad_dispatch_pkg.sv
// Shared constants and types for the ocra1 gradient dispatcher.
// Sample layout and channel indices match the ocra1_iface serialiser.
package ocra1_grad_dispatch_pkg;

    localparam int OCRA1_DW = 24;
    localparam int SAMPLE_W = 4 * OCRA1_DW;

    localparam logic [1:0] CH_X  = 2'd0;
    localparam logic [1:0] CH_Y  = 2'd1;
    localparam logic [1:0] CH_Z  = 2'd2;
    localparam logic [1:0] CH_Z2 = 2'd3;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef struct packed {
        logic [OCRA1_DW-1:0] x;
        logic [OCRA1_DW-1:0] y;
        logic [OCRA1_DW-1:0] z;
        logic [OCRA1_DW-1:0] z2;
    } sample_t;

endpackage

// File: rtl/ocra1_sample_fifo.sv
// First-word-fall-through sample FIFO with flush.
// A push into a full FIFO is taken only when a pop frees the slot.
module ocra1_sample_fifo #(
    parameter int AW = 4,
    parameter int W  = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ocra1_grad_dispatch.sv
// Gradient sample feeder: stages x/y/z, commits on z2, and issues one
// buffered sample to ocra1_iface per update interval.
module ocra1_grad_dispatch
    import ocra1_grad_dispatch_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int INT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_i,
    input  logic [1:0]          chan_i,
    input  logic [OCRA1_DW-1:0] data_i,
    input  logic [INT_W-1:0]    interval_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                clear_i,
    input  logic                busy_i,
    output logic [OCRA1_DW-1:0] datax_o,
    output logic [OCRA1_DW-1:0] datay_o,
    output logic [OCRA1_DW-1:0] dataz_o,
    output logic [OCRA1_DW-1:0] dataz2_o,
    output logic                valid_o,
    output logic                running_o,
    output logic [FIFO_AW:0]    count_o,
    output logic                overflow_o,
    output logic                underrun_o,
    output logic                stall_o
);

    state_e              state_q;
    logic [INT_W-1:0]    cnt_q;
    logic [OCRA1_DW-1:0] x_stg_q;
    logic [OCRA1_DW-1:0] y_stg_q;
    logic [OCRA1_DW-1:0] z_stg_q;
    sample_t             data_q;
    logic                valid_q;
    logic                ovf_q;
    logic                und_q;
    logic                stall_q;

    sample_t             push_d;
    sample_t             head;
    logic                push;
    logic                full;
    logic                empty;
    logic                tick;
    logic                live_tick;
    logic                issue;

    assign push   = wr_i && (chan_i == CH_Z2);
    assign push_d = '{x: x_stg_q, y: y_stg_q, z: z_stg_q, z2: data_i};

    // stop and clear both swallow the tick entirely
    assign tick      = (state_q == RUN) && (cnt_q == '0);
    assign live_tick = tick && !stop_i && !clear_i;
    assign issue     = live_tick && !busy_i && !empty;

    ocra1_sample_fifo #(
        .AW (FIFO_AW),
        .W  (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (issue),
        .flush_i (clear_i),
        .din_i   (push_d),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_stg_q <= '0;
            y_stg_q <= '0;
            z_stg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            und_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            valid_q <= issue;
            if (issue) begin
                data_q <= head;
            end

            if (wr_i) begin
                unique case (chan_i)
                    CH_X:    x_stg_q <= data_i;
                    CH_Y:    y_stg_q <= data_i;
                    CH_Z:    z_stg_q <= data_i;
                    default: ;
                endcase
            end

            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - INT_W'(1);
                    end else if (issue) begin
                        cnt_q <= interval_i;
                    end else if (live_tick && !busy_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (clear_i) begin
                ovf_q   <= 1'b0;
                und_q   <= 1'b0;
                stall_q <= 1'b0;
            end else begin
                if (push && full && !issue) begin
                    ovf_q <= 1'b1;
                end
                if (live_tick && busy_i) begin
                    stall_q <= 1'b1;
                end
                if (live_tick && !busy_i && empty) begin
                    und_q <= 1'b1;
                end
            end
        end
    end

    assign datax_o    = data_q.x;
    assign datay_o    = data_q.y;
    assign dataz_o    = data_q.z;
    assign dataz2_o   = data_q.z2;
    assign valid_o    = valid_q;
    assign running_o  = (state_q == RUN);
    assign overflow_o = ovf_q;
    assign underrun_o = und_q;
    assign stall_o    = stall_q;

endmodule

// File: tb/tb_ocra1_grad_dispatch.sv
// Directed bench for ocra1_grad_dispatch: inputs driven and outputs
// sampled on the falling edge, one linear sequence of steps.
module tb_ocra1_grad_dispatch;

    logic        clk;
    logic        rst_n;
    logic        wr_i;
    logic [1:0]  chan_i;
    logic [23:0] data_i;
    logic [15:0] interval_i;
    logic        start_i;
    logic        stop_i;
    logic        clear_i;
    logic        busy_i;
    logic [23:0] datax_o;
    logic [23:0] datay_o;
    logic [23:0] dataz_o;
    logic [23:0] dataz2_o;
    logic        valid_o;
    logic        running_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic        underrun_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;

    ocra1_grad_dispatch #(.FIFO_AW(4), .INT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (wr_i),
        .chan_i     (chan_i),
        .data_i     (data_i),
        .interval_i (interval_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .clear_i    (clear_i),
        .busy_i     (busy_i),
        .datax_o    (datax_o),
        .datay_o    (datay_o),
        .dataz_o    (dataz_o),
        .dataz2_o   (dataz2_o),
        .valid_o    (valid_o),
        .running_o  (running_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .underrun_o (underrun_o),
        .stall_o    (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [23:0] d);
        wr_i   = 1'b1;
        chan_i = ch;
        data_i = d;
        step();
        wr_i   = 1'b0;
    endtask

    task automatic commit(input logic [23:0] x, input logic [23:0] y,
                          input logic [23:0] z, input logic [23:0] z2);
        wr(2'd0, x);
        wr(2'd1, y);
        wr(2'd2, z);
        wr(2'd3, z2);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    // cycles until valid_o is seen; -1 when the budget runs out
    task automatic wait_valid(input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid_o && n < lim);
        if (!valid_o) n = -1;
    endtask

    initial begin : main
        int n;
        int vcnt;
        rst_n = 1'b0; wr_i = 1'b0; chan_i = '0; data_i = '0;
        interval_i = '0; start_i = 1'b0; stop_i = 1'b0;
        clear_i = 1'b0; busy_i = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_running", running_o, 0);
        chk("rst_datax", datax_o, 0);
        repeat (2) step();
        rst_n = 1'b1;
        vcnt = 0;
        repeat (5) begin
            step();
            if (valid_o) vcnt++;
        end
        chk("idle_no_valid", vcnt, 0);

        interval_i = 16'd99;
        commit(24'd1, 24'd2, 24'd3, 24'd4);
        commit(24'd5, 24'd6, 24'd7, 24'd8);
        commit(24'd9, 24'd10, 24'd11, 24'd12);
        chk("run_count3", count_o, 3);
        pulse_start();
        chk("run_running", running_o, 1);
        wait_valid(200, n);
        chk("run_first_lat", n, 1);
        chk("run_d0x", datax_o, 1);
        chk("run_d0y", datay_o, 2);
        chk("run_d0z", dataz_o, 3);
        chk("run_d0z2", dataz2_o, 4);
        chk("run_count2", count_o, 2);
        wait_valid(200, n);
        chk("run_second_gap", n, 100);
        chk("run_d1x", datax_o, 5);
        chk("run_d1z2", dataz2_o, 8);
        wait_valid(200, n);
        chk("run_third_gap", n, 100);
        chk("run_d2x", datax_o, 9);
        chk("run_d2z2", dataz2_o, 12);
        repeat (99) step();
        chk("run_tick_running", running_o, 1);
        chk("run_tick_no_und", underrun_o, 0);
        step();
        chk("run_underrun", underrun_o, 1);
        chk("run_stopped", running_o, 0);
        chk("run_no_valid", valid_o, 0);
        chk("run_hold_x", datax_o, 9);

        pulse_clear();
        chk("clr_underrun", underrun_o, 0);
        for (int i = 0; i < 17; i++)
            commit(24'(i), 24'(i + 'h100), 24'(i + 'h200), 24'(i + 'h1000));
        chk("ovf_count", count_o, 16);
        chk("ovf_flag", overflow_o, 1);
        interval_i = 16'd0;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_valid", valid_o, 1);
            chk("drain_x", datax_o, i);
            chk("drain_z2", dataz2_o, 'h1000 + i);
        end
        step();
        chk("drain_no17", valid_o, 0);
        chk("drain_und", underrun_o, 1);
        chk("drain_idle", running_o, 0);
        chk("drain_hold", dataz2_o, 'h100F);
        pulse_clear();
        chk("clr_count", count_o, 0);
        chk("clr_ovf", overflow_o, 0);
        chk("clr_und", underrun_o, 0);
        chk("clr_stall", stall_o, 0);

        for (int i = 0; i < 16; i++)
            commit(24'(i + 'h50), 24'd0, 24'd0, 24'd0);
        chk("full_count", count_o, 16);
        interval_i = 16'd3;
        pulse_start();
        wr(2'd3, 24'hABC);
        chk("pp_valid", valid_o, 1);
        chk("pp_x", datax_o, 'h50);
        chk("pp_count", count_o, 16);
        chk("pp_ovf", overflow_o, 0);
        repeat (3) step();
        pulse_stop();
        chk("stop_no_valid", valid_o, 0);
        chk("stop_idle", running_o, 0);
        chk("stop_count", count_o, 16);
        chk("stop_hold_x", datax_o, 'h50);
        repeat (3) step();
        chk("stop_still_idle", valid_o, 0);
        pulse_start();
        step();
        chk("resume_valid", valid_o, 1);
        chk("resume_x", datax_o, 'h51);
        chk("resume_count", count_o, 15);
        pulse_stop();
        pulse_clear();

        commit(24'hA0, 24'd0, 24'd0, 24'd1);
        commit(24'hB0, 24'd0, 24'd0, 24'd2);
        interval_i = 16'd5;
        pulse_start();
        wait_valid(20, n);
        chk("stall_first_lat", n, 1);
        chk("stall_first_x", datax_o, 'hA0);
        busy_i = 1'b1;
        vcnt = 0;
        repeat (20) begin
            step();
            if (valid_o) vcnt++;
        end
        busy_i = 1'b0;
        chk("stall_no_valid", vcnt, 0);
        chk("stall_flag", stall_o, 1);
        step();
        chk("stall_release", valid_o, 1);
        chk("stall_second_x", datax_o, 'hB0);
        pulse_stop();
        pulse_clear();

        commit(24'h77, 24'd0, 24'd0, 24'd0);
        interval_i = 16'd0;
        pulse_start();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_running", running_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_datax", datax_o, 0);
        chk("mid_rst_stall", stall_o, 0);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (4) begin
            step();
            if (valid_o) vcnt++;
        end
        chk("mid_rst_lost", vcnt, 0);
        chk("mid_rst_data_kept0", datax_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
